// File: rtl/aoi222_arc_stim_pkg.sv
// Shared types and constants for the AOI222 arc stimulus generator.
// Pair encodings pack a pin pair as {pin1, pin2}.
package aoi222_arc_stim_pkg;

  localparam int unsigned N_ARC   = 6;
  localparam int unsigned N_COND  = 9;
  localparam int unsigned N_PHASE = 3;
  localparam int unsigned N_STEP  = N_ARC * N_COND * N_PHASE;

  localparam int unsigned ARC_W   = 3;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned CODE_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Target pin low, target pin high, target pin returned low
  typedef enum logic [PHASE_W-1:0] {
    PH_LOW  = 2'd0,
    PH_HIGH = 2'd1,
    PH_RET  = 2'd2
  } phase_e;

  typedef logic [1:0] pair_t;

  typedef struct packed {
    pair_t a;
    pair_t b;
    pair_t c;
    logic  exp_zn;
  } vec_t;

  // Side-pair code to pins; the (1,1) combination is never produced
  function automatic pair_t pair_pins(logic [CODE_W-1:0] code);
    pair_t p;
    unique case (code)
      2'd1:    p = 2'b01;
      2'd2:    p = 2'b10;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/aoi222_arc_vec_dec.sv
// Maps a (ARC, COND, PHASE) step onto the six AOI222 input pins and the
// expected ZN; all-zero whenever en is low.
module aoi222_arc_vec_dec
  import aoi222_arc_stim_pkg::*;
(
  input  logic              en,
  input  logic [ARC_W-1:0]  arc,
  input  logic [COND_W-1:0] cond,
  input  phase_e            phase,
  output vec_t              vec_c
);

  logic  tgt;
  pair_t tgt_pair;
  pair_t side_hi;
  pair_t side_lo;

  always_comb begin
    vec_c    = '0;
    tgt      = (phase == PH_HIGH);
    // Sibling of the target is held high so the target alone controls its AND term
    tgt_pair = arc[0] ? {1'b1, tgt} : {tgt, 1'b1};
    side_hi  = pair_pins(CODE_W'(cond / COND_W'(3)));
    side_lo  = pair_pins(CODE_W'(cond % COND_W'(3)));
    if (en) begin
      unique case (arc[2:1])
        2'd0: begin
          vec_c.a = tgt_pair;
          vec_c.b = side_hi;
          vec_c.c = side_lo;
        end
        2'd1: begin
          vec_c.a = side_hi;
          vec_c.b = tgt_pair;
          vec_c.c = side_lo;
        end
        default: begin
          vec_c.a = side_hi;
          vec_c.b = side_lo;
          vec_c.c = tgt_pair;
        end
      endcase
      vec_c.exp_zn = (phase != PH_HIGH);
    end
  end

endmodule

// File: rtl/aoi222_arc_stim.sv
// Walks every AOI222 timing arc (target pin x side condition x phase),
// drives the pins with a valid/ready handshake and counts ZN mismatches.
module aoi222_arc_stim
  import aoi222_arc_stim_pkg::*;
#(
  parameter int unsigned ERR_W = 8
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic               START,
  input  logic               RDY,
  input  logic               ZN_IN,
  output logic               A1,
  output logic               A2,
  output logic               B1,
  output logic               B2,
  output logic               C1,
  output logic               C2,
  output logic               EXP_ZN,
  output logic               VLD,
  output logic [ARC_W-1:0]   ARC,
  output logic [COND_W-1:0]  COND,
  output logic [PHASE_W-1:0] PHASE,
  output logic               BUSY,
  output logic               DONE,
  output logic [ERR_W-1:0]   ERR_CNT
);

  state_e             state_q, state_d;
  logic [ARC_W-1:0]   arc_q, arc_d;
  logic [COND_W-1:0]  cond_q, cond_d;
  phase_e             phase_q, phase_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               vld_q;
  logic               done_q;
  logic               last_step;
  vec_t               vec;

  aoi222_arc_vec_dec u_dec (
    .en    (vld_q),
    .arc   (arc_q),
    .cond  (cond_q),
    .phase (phase_q),
    .vec_c (vec)
  );

  assign last_step = (arc_q == ARC_W'(N_ARC - 1)) && (cond_q == COND_W'(N_COND - 1))
                     && (phase_q == PH_RET);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      arc_q   <= '0;
      cond_q  <= '0;
      phase_q <= PH_LOW;
      err_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arc_q   <= arc_d;
      cond_q  <= cond_d;
      phase_q <= phase_d;
      err_q   <= err_d;
      vld_q   <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_FIN);
    end
  end

  // Next state, step counters (phase innermost) and saturating error count
  always_comb begin
    state_d = state_q;
    arc_d   = arc_q;
    cond_d  = cond_q;
    phase_d = phase_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          state_d = ST_RUN;
          arc_d   = '0;
          cond_d  = '0;
          phase_d = PH_LOW;
          err_d   = '0;
        end
      end
      ST_RUN: begin
        if (RDY) begin
          if ((ZN_IN != vec.exp_zn) && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
          end
          if (last_step) begin
            state_d = ST_FIN;
            arc_d   = '0;
            cond_d  = '0;
            phase_d = PH_LOW;
          end else begin
            unique case (phase_q)
              PH_LOW:  phase_d = PH_HIGH;
              PH_HIGH: phase_d = PH_RET;
              default: begin
                phase_d = PH_LOW;
                if (cond_q == COND_W'(N_COND - 1)) begin
                  cond_d = '0;
                  arc_d  = arc_q + ARC_W'(1);
                end else begin
                  cond_d = cond_q + COND_W'(1);
                end
              end
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign A1      = vec.a[1];
  assign A2      = vec.a[0];
  assign B1      = vec.b[1];
  assign B2      = vec.b[0];
  assign C1      = vec.c[1];
  assign C2      = vec.c[0];
  assign EXP_ZN  = vec.exp_zn;
  assign VLD     = vld_q;
  assign BUSY    = vld_q;
  assign DONE    = done_q;
  assign ARC     = arc_q;
  assign COND    = cond_q;
  assign PHASE   = phase_q;
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_aoi222_arc_stim.sv
// Randomized bench for aoi222_arc_stim against a step-index reference model;
// a second instance with ERR_W=4 shares the stimulus to cover saturation.
module tb_aoi222_arc_stim;

  logic       CLK = 1'b0;
  logic       RN = 1'b0;
  logic       START = 1'b0;
  logic       RDY = 1'b0;
  logic       ZN_IN = 1'b0;

  logic       A1, A2, B1, B2, C1, C2, EXP_ZN, VLD, BUSY, DONE;
  logic [2:0] ARC;
  logic [3:0] COND;
  logic [1:0] PHASE;
  logic [7:0] ERR_CNT;

  logic       w4_a1, w4_a2, w4_b1, w4_b2, w4_c1, w4_c2, w4_exp_zn, w4_vld, w4_busy, w4_done;
  logic [2:0] w4_arc;
  logic [3:0] w4_cond;
  logic [1:0] w4_phase;
  logic [3:0] w4_err_cnt;

  aoi222_arc_stim #(.ERR_W(8)) dut (
    .CLK(CLK), .RN(RN), .START(START), .RDY(RDY), .ZN_IN(ZN_IN),
    .A1(A1), .A2(A2), .B1(B1), .B2(B2), .C1(C1), .C2(C2),
    .EXP_ZN(EXP_ZN), .VLD(VLD), .ARC(ARC), .COND(COND), .PHASE(PHASE),
    .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT)
  );

  aoi222_arc_stim #(.ERR_W(4)) dut_w4 (
    .CLK(CLK), .RN(RN), .START(START), .RDY(RDY), .ZN_IN(ZN_IN),
    .A1(w4_a1), .A2(w4_a2), .B1(w4_b1), .B2(w4_b2), .C1(w4_c1), .C2(w4_c2),
    .EXP_ZN(w4_exp_zn), .VLD(w4_vld), .ARC(w4_arc), .COND(w4_cond), .PHASE(w4_phase),
    .BUSY(w4_busy), .DONE(w4_done), .ERR_CNT(w4_err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int m_state  = 0;  // 0 idle, 1 running, 2 finished
  int m_step   = 0;
  int m_err    = 0;
  int dut_hs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pins {C2,C1,B2,B1,A2,A1} for step index s, straight from the arc rules
  function automatic logic [5:0] model_pins(input int s);
    int arc = s / 27;
    int cond = (s / 3) % 9;
    int ph = s % 3;
    int code[2];
    int k = 0;
    logic [5:0] p = '0;
    code[0] = cond / 3;
    code[1] = cond % 3;
    for (int g = 0; g < 3; g++) begin
      if (g != arc / 2) begin
        p[2*g]   = (code[k] == 2);
        p[2*g+1] = (code[k] == 1);
        k++;
      end
    end
    p[arc]     = (ph == 1);
    p[arc ^ 1] = 1'b1;
    return p;
  endfunction

  function automatic logic aoi(input logic [5:0] p);
    return !((p[0] & p[1]) | (p[2] & p[3]) | (p[4] & p[5]));
  endfunction

  task automatic check_outputs();
    logic [5:0] pins = {C2, C1, B2, B1, A2, A1};
    check("vld", VLD, m_state == 1);
    check("busy", BUSY, m_state == 1);
    check("done", DONE, m_state == 2);
    check("err_cnt", ERR_CNT, (m_err > 255) ? 255 : m_err);
    check("err_cnt_w4", w4_err_cnt, (m_err > 15) ? 15 : m_err);
    if (m_state == 1) begin
      check("arc", ARC, m_step / 27);
      check("cond", COND, (m_step / 3) % 9);
      check("phase", PHASE, m_step % 3);
      check("pins", pins, model_pins(m_step));
      check("exp_zn", EXP_ZN, aoi(model_pins(m_step)));
    end else begin
      check("pins_off", pins, 0);
      check("exp_zn_off", EXP_ZN, 0);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_pins"}, {C2, C1, B2, B1, A2, A1}, 0);
    check({tag, "_exp_zn"}, EXP_ZN, 0);
    check({tag, "_vld"}, VLD, 0);
    check({tag, "_step"}, {ARC, COND, PHASE}, 0);
    check({tag, "_busy_done"}, {BUSY, DONE}, 0);
    check({tag, "_err"}, ERR_CNT, 0);
    check({tag, "_err_w4"}, w4_err_cnt, 0);
  endtask

  // One clock: drive at negedge, check, then advance the model on the edge
  task automatic cycle(input bit start, input bit rdy, input int zn_mode);
    logic [5:0] p = (m_state == 1) ? model_pins(m_step) : 6'd0;
    bit zn;
    case (zn_mode)
      0:       zn = aoi(p);
      1:       zn = 1'b1;
      default: zn = 1'($urandom_range(1));
    endcase
    START = start;
    RDY   = rdy;
    ZN_IN = zn;
    check_outputs();
    if (VLD && rdy) dut_hs++;
    @(posedge CLK);
    case (m_state)
      1: begin
        if (rdy) begin
          if (zn != aoi(p)) m_err++;
          if (m_step == 161) m_state = 2;
          else m_step++;
        end
      end
      default: begin
        if (start) begin
          m_state = 1;
          m_step  = 0;
          m_err   = 0;
        end
      end
    endcase
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(1)), 2);
  endtask

  task automatic run(input int zn_mode, input int rdy_pct, input int stall_at,
                     input int start_at, input int rst_at);
    int budget = 2000;
    int stall = 0;
    bit rdy;
    bit st;
    dut_hs = 0;
    cycle(1'b1, 1'b1, zn_mode);
    while (m_state == 1 && budget > 0) begin
      budget--;
      if (m_step == rst_at) begin
        #2 RN = 1'b0;
        #1;
        m_state = 0;
        m_step  = 0;
        m_err   = 0;
        check_reset_zero("rst_async");
        @(negedge CLK);
        #2 RN = 1'b1;
        @(negedge CLK);
        return;
      end
      rdy = ($urandom_range(99) < rdy_pct);
      if (m_step == stall_at && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end
      st = (m_step == start_at) || ($urandom_range(15) == 0);
      cycle(st, rdy, zn_mode);
    end
    if (m_state != 2) check("run_timeout_done", DONE, 1);
    else check("handshakes", dut_hs, 162);
  endtask

  initial begin
    RN = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_zero("por");
    #2 RN = 1'b1;
    @(negedge CLK);
    idle_cycles(6);

    // Correct AOI222 responses, stall at step 20, stray START at step 10
    run(0, 100, 20, 10, -1);
    check("run1_done", DONE, 1);
    check("run1_err", ERR_CNT, 0);
    idle_cycles(4);

    // ZN stuck at 1: every PHASE 1 step mismatches
    run(1, 70, -1, -1, -1);
    check("run2_err", ERR_CNT, 54);
    check("run2_err_w4", w4_err_cnt, 15);
    idle_cycles(3);

    // Random ZN, reset asserted mid-run, then a clean rerun
    run(2, 80, -1, -1, 40);
    idle_cycles(5);
    run(0, 60, -1, -1, -1);
    check("run4_done", DONE, 1);
    check("run4_err", ERR_CNT, 0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aoi222_arc_stim.md
AOI222_ARC_STIM -- requirements
Module: aoi222_arc_stim

Interface
REQ-001 SHALL have parameter ERR_W, default 8, width of the mismatch counter.
REQ-002 SHALL have a single clock; reset is asynchronous and active-low (ports CLK, RN).
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RN  input  1  asynchronous active-low reset.
REQ-005 START  input  1  one-cycle run request.
REQ-006 RDY  input  1  consumer ready; a step completes on VLD&RDY.
REQ-007 ZN_IN  input  1  observed ZN of the AOI222 under test, sampled on VLD&RDY.
REQ-008 A1, A2, B1, B2, C1, C2  output  1 each  stimulus pins driving the AOI222 inputs.
REQ-009 EXP_ZN  output  1  expected ZN for the current step.
REQ-010 VLD  output  1  stimulus pins and EXP_ZN are valid.
REQ-011 ARC  output  3  target pin index: 0=A1, 1=A2, 2=B1, 3=B2, 4=C1, 5=C2.
REQ-012 COND  output  4  side-condition index, 0..8.
REQ-013 PHASE  output  2  phase index, 0..2.
REQ-014 BUSY  output  1  run in progress.
REQ-015 DONE  output  1  run complete.
REQ-016 ERR_CNT  output  ERR_W  count of ZN mismatches.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN and FIN.
REQ-018 IDLE and START: the next cycle SHALL be RUN with VLD=1, BUSY=1 and step (ARC=0, COND=0, PHASE=0).
REQ-019 The step order SHALL be nested with PHASE innermost, then COND, then ARC, giving 6*9*3=162 steps.
REQ-020 Sibling pin of the target (A1<->A2, B1<->B2, C1<->C2) SHALL be 1.
REQ-021 The target pin SHALL be 0 in PHASE 0, 1 in PHASE 1 and 0 in PHASE 2.
REQ-022 Side pairs SHALL be (B,C) for A targets, (A,C) for B targets and (A,B) for C targets.
REQ-023 For the side pairs, the first pair code SHALL be COND/3 and the second pair code SHALL be COND%3.
REQ-024 Pair code encoding (pin1,pin2) SHALL be: 0=(0,0), 1=(0,1), 2=(1,0); (1,1) is never driven.
REQ-025 EXP_ZN SHALL be 1 in PHASE 0 and 2, and 0 in PHASE 1.
REQ-026 Outputs SHALL hold stable while VLD=1 and RDY=0, for any number of cycles.
REQ-027 On VLD&RDY, the step SHALL advance on the next edge, and VLD SHALL stay 1, giving back-to-back throughput of one step per cycle.
REQ-028 On VLD&RDY with ZN_IN!=EXP_ZN, ERR_CNT SHALL increment, saturating at 2^ERR_W-1.
REQ-029 On the handshake of step 161 (ARC=5, COND=8, PHASE=2), the next cycle SHALL be FIN with VLD=0, BUSY=0 and DONE=1.
REQ-030 In FIN, the stimulus pins SHALL be 0, and DONE and ERR_CNT SHALL hold.
REQ-031 START in RUN SHALL be ignored.
REQ-032 START in FIN SHALL clear DONE and ERR_CNT and restart from step 0 with IDLE timing.
REQ-033 RDY and ZN_IN SHALL be ignored when VLD=0.

Reset
REQ-034 RN low SHALL immediately force IDLE with all outputs 0 (pins, EXP_ZN, VLD, ARC, COND, PHASE, BUSY, DONE, ERR_CNT), including mid-run.
REQ-035 After RN rises, nothing SHALL happen until START.

Structure
REQ-036 Package aoi222_arc_stim_pkg SHALL hold:
- the state and phase enums;
- N_ARC=6, N_COND=9, N_PHASE=3, N_STEP=162;
- the pair-code-to-pins function.
REQ-037 Combinational sub-module aoi222_arc_vec_dec SHALL map (ARC, COND, PHASE) to the six pins and EXP_ZN.
REQ-038 The top module SHALL hold only the FSM, the step counters and ERR_CNT.

Verification
REQ-039 START, RDY=1, ZN_IN from a correct AOI222 model -> 162 handshakes, then DONE=1, ERR_CNT=0.
REQ-040 First two steps -> step 0: A1=0, A2=1, B=00, C=00, EXP_ZN=1; step 1: A1=1, EXP_ZN=0; step 3: COND=1, C2=1.
REQ-041 RDY low for 5 cycles at step 20 -> VLD=1 and all outputs unchanged throughout; advance one cycle after RDY rises.
REQ-042 ZN_IN tied 1 -> ERR_CNT=54 at DONE; with ERR_W=4 -> ERR_CNT=15 (saturated).
REQ-043 RN low at step 40 -> outputs 0 asynchronously; next START restarts at step 0 with ERR_CNT=0.
REQ-044 START pulsed at step 10 -> ignored; START in FIN -> DONE=0, ERR_CNT=0, new run.
